num_check: RTL and testbench
============================

Name: num_check

Overview:
- AXI-Stream sink at the far end of the NoC from the number generator. Accepts packets addressed to this node, checks each beat against the generator's format: zero pad, 8-bit LFSR payload, fixed TID/TDEST, fixed length.
- Reports per-packet pass/fail, plus saturating packet/error counters and sticky error flags for the bench and status logic.

Parameters:
TDATAW, 32, stream data width
TDESTW, 4, TDEST width
TIDW, 2, TID width
LFSR_DW, 7, MSB index of LFSR payload (payload = LFSR_DW+1 bits)
NUM_PACKETS, 1, beats per packet (>=1); TLAST required on last beat
MY_DEST, 4'h1, expected TDEST
CHECK_SEQ, 1, 1 = enable LFSR sequence check
CNTW, 16, counter width

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-high reset
EN  in  1  enables acceptance; 0 = TREADY low, state held
CLR  in  1  synchronous clear of counters and sticky flags
AXIS_S_TVALID  in  1  slave valid
AXIS_S_TREADY  out  1  slave ready
AXIS_S_TDATA  in  TDATAW  data: {zero pad, payload}
AXIS_S_TLAST  in  1  last beat
AXIS_S_TID  in  TIDW  must be 0
AXIS_S_TDEST  in  TDESTW  must equal MY_DEST
PKT_DONE  out  1  one-cycle pulse per completed packet
PKT_OK  out  1  valid with PKT_DONE: 1 = packet error-free
PKT_CNT  out  CNTW  packets completed (saturating)
ERR_CNT  out  CNTW  failed packets (saturating)
ERR_FLAGS  out  5  sticky {len, seq, id, dest, pad}, bits 4..0
LAST_DATA  out  LFSR_DW+1  payload of most recently accepted beat

Behaviour:
- Beat accepted when TVALID & TREADY on a rising CLK.
- TREADY is combinational: EN & (state != REPORT).
- Reset (RST=1, async): state IDLE, all outputs 0, beat count 0, per-packet error accumulator 0.
- Reset mid-packet discards the packet with no PKT_DONE.
- States:
  - IDLE: first accepted beat -> RECV. If that beat has TLAST, or NUM_PACKETS==1, go straight to REPORT.
  - RECV: TLAST beat -> REPORT. Beat NUM_PACKETS accepted without TLAST -> DRAIN, set len error.
  - DRAIN: accepts and discards beats, no data checks. TLAST beat -> REPORT.
  - REPORT: exactly one cycle. PKT_DONE=1 and PKT_OK=~(any packet error). PKT_CNT+=1; ERR_CNT+=1 if error. Clear per-packet accumulator -> IDLE.
- Latency: PKT_DONE asserts the cycle after the TLAST beat is accepted. TREADY is low during that cycle.
- Per-beat checks, accumulated per packet and ORed into sticky ERR_FLAGS:
  - pad: TDATA[TDATAW-1:LFSR_DW+1] != 0
  - dest: TDEST != MY_DEST
  - id: TID != 0
  - len: TLAST on beat index < NUM_PACKETS-1, or overlength as above
  - seq (CHECK_SEQ=1 only): beat index > 0 and the previous beat was accepted in the immediately preceding cycle, and payload != lfsr_next(previous payload). No seq check after any gap cycle, since the generator LFSR free-runs across stalls.
- lfsr_next(d) = {d[6:0], d[7]^d[5]^d[4]^d[3]} (8-bit Fibonacci, shared with the generator).
- Counters saturate at all-ones, no wrap.
- CLR clears PKT_CNT, ERR_CNT, ERR_FLAGS. It does not affect state or the in-flight accumulator.
  - CLR in the REPORT cycle: CLR wins, counters read 0 after.
  - PKT_DONE/PKT_OK still pulse.
- EN falling mid-packet: TREADY drops and state, counts and accumulator are held. Seq continuity breaks.
- LAST_DATA updates on every accepted beat, including in DRAIN.

Decomposition:
- Package num_noc_pkg:
  - state enum {IDLE, RECV, DRAIN, REPORT}
  - ERR_* bit-index localparams
  - function lfsr_next, shared with the generator's LFSR model
- Sub-module sat_counter (CNTW, inc, clr), instantiated for PKT_CNT and ERR_CNT.

Test Plan:
- NUM_PACKETS=4, MY_DEST=1: back-to-back beats 0x01,0x02,0x04,0x08, TLAST on the 4th -> PKT_DONE one cycle later, PKT_OK=1, PKT_CNT=1, ERR_CNT=0, ERR_FLAGS=0, LAST_DATA=0x08.
- Payloads 0x01,0x02,0x05,0x08 back-to-back -> PKT_OK=0, ERR_FLAGS=5'b01000, ERR_CNT=1. Same stream with an idle cycle before 0x11 (0x01,0x02,0x04,gap,0x11) -> PKT_OK=1.
- TLAST on 2nd beat -> REPORT after beat 2, len flag set. Six beats with TLAST on 6th -> beats 5-6 drained, single PKT_DONE, PKT_OK=0, ERR_FLAGS[4]=1.
- Beat with TDATA=0x0000_0101, TDEST=2, TID=1 -> ERR_FLAGS=5'b00111. Then CLR -> flags and counters 0, next clean packet gives PKT_OK=1.
- RST pulsed after beat 2 of 4 -> TREADY=0 during reset, no PKT_DONE. A following full packet passes with PKT_CNT=1.
- EN=0 for 3 cycles mid-packet with TVALID=1 -> TREADY=0, no beats accepted. Resume -> packet completes with PKT_OK=1 (seq skipped at gap). Drive PKT_CNT to 0xFFFF -> stays 0xFFFF.

Source files
------------

// File: rtl/num_noc_pkg.sv
// Shared definitions for the number generator / checker NoC pair:
// checker FSM states, error-flag bit positions and the payload LFSR step.
package num_noc_pkg;

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, REPORT} state_e;

  localparam int unsigned ERR_PAD  = 0;
  localparam int unsigned ERR_DEST = 1;
  localparam int unsigned ERR_ID   = 2;
  localparam int unsigned ERR_SEQ  = 3;
  localparam int unsigned ERR_LEN  = 4;
  localparam int unsigned NUM_ERR  = 5;

  // 8-bit Fibonacci step, identical to the generator's free-running LFSR
  function automatic logic [7:0] lfsr_next(input logic [7:0] d);
    return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
  endfunction

endpackage

// File: rtl/num_check_if.sv
// AXI-Stream link between the NoC and the number checker sink.
interface num_check_if #(
  parameter int unsigned TDATAW = 32,
  parameter int unsigned TDESTW = 4,
  parameter int unsigned TIDW   = 2
);
  logic              tvalid;
  logic              tready;
  logic [TDATAW-1:0] tdata;
  logic              tlast;
  logic [TIDW-1:0]   tid;
  logic [TDESTW-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority.
module sat_counter #(
  parameter int unsigned CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            inc,
  input  logic            clr,
  output logic [CNTW-1:0] cnt
);
  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/num_check.sv
// AXI-Stream sink that checks generator packets (pad, LFSR payload, TID/TDEST,
// length) and reports per-packet pass/fail with saturating counters.
module num_check
  import num_noc_pkg::*;
#(
  parameter int unsigned        TDATAW      = 32,
  parameter int unsigned        TDESTW      = 4,
  parameter int unsigned        TIDW        = 2,
  parameter int unsigned        LFSR_DW     = 7,
  parameter int unsigned        NUM_PACKETS = 1,
  parameter logic [TDESTW-1:0]  MY_DEST     = TDESTW'(1),
  parameter bit                 CHECK_SEQ   = 1'b1,
  parameter int unsigned        CNTW        = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               CLR,
  num_check_if.slave         AXIS_S,
  output logic               PKT_DONE,
  output logic               PKT_OK,
  output logic [CNTW-1:0]    PKT_CNT,
  output logic [CNTW-1:0]    ERR_CNT,
  output logic [NUM_ERR-1:0] ERR_FLAGS,
  output logic [LFSR_DW:0]   LAST_DATA
);
  localparam int unsigned PW  = LFSR_DW + 1;
  localparam int unsigned BCW = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;

  state_e             state_q, state_d;
  logic [BCW-1:0]     idx_q, idx_d;
  logic [NUM_ERR-1:0] acc_q, acc_d;
  logic [NUM_ERR-1:0] flags_q, flags_d;
  logic [PW-1:0]      last_q;
  logic               prev_acc_q;

  logic               accept;
  logic               final_beat;
  logic [PW-1:0]      payload;
  logic [NUM_ERR-1:0] beat_err;

  assign AXIS_S.tready = EN & ~RST & (state_q != REPORT);
  assign accept        = AXIS_S.tvalid & AXIS_S.tready;
  assign payload       = AXIS_S.tdata[PW-1:0];
  assign final_beat    = (idx_q == BCW'(NUM_PACKETS - 1));

  // Seq is only meaningful for beats accepted on consecutive cycles, because
  // the generator LFSR keeps stepping while the link is stalled.
  always_comb begin
    beat_err           = '0;
    beat_err[ERR_PAD]  = |AXIS_S.tdata[TDATAW-1:PW];
    beat_err[ERR_DEST] = (AXIS_S.tdest != MY_DEST);
    beat_err[ERR_ID]   = |AXIS_S.tid;
    beat_err[ERR_SEQ]  = CHECK_SEQ && (idx_q != '0) && prev_acc_q &&
                         (payload != lfsr_next(last_q));
    beat_err[ERR_LEN]  = AXIS_S.tlast ? ~final_beat : final_beat;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    unique case (state_q)
      IDLE, RECV: begin
        if (accept) begin
          acc_d   = acc_q | beat_err;
          flags_d = flags_q | beat_err;
          if (AXIS_S.tlast) begin
            state_d = REPORT;
          end else if (final_beat) begin
            state_d = (state_q == IDLE) ? REPORT : DRAIN;
          end else begin
            state_d = RECV;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && AXIS_S.tlast) state_d = REPORT;
      end
      REPORT: begin
        state_d = IDLE;
        idx_d   = '0;
        acc_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (CLR) flags_d = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      flags_q    <= '0;
      last_q     <= '0;
      prev_acc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      flags_q    <= flags_d;
      prev_acc_q <= accept;
      if (accept) last_q <= payload;
    end
  end

  assign PKT_DONE  = (state_q == REPORT);
  assign PKT_OK    = PKT_DONE & ~(|acc_q);
  assign ERR_FLAGS = flags_q;
  assign LAST_DATA = last_q;

  sat_counter #(.CNTW(CNTW)) u_pkt_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (PKT_DONE),
    .clr (CLR),
    .cnt (PKT_CNT)
  );

  sat_counter #(.CNTW(CNTW)) u_err_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (PKT_DONE & ~PKT_OK),
    .clr (CLR),
    .cnt (ERR_CNT)
  );
endmodule

// File: tb/tb_num_check.sv
// Randomised + directed bench for num_check with a packet-level reference
// model feeding a scoreboard that a separate monitor drains on PKT_DONE.
module tb_num_check;
  localparam int NP   = 4;
  localparam int CNTW = 5;
  localparam logic [CNTW-1:0] CMAX = '1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  tid;
    logic [3:0]  dest;
    bit          gap;
    bit          pause;
  } beat_t;

  typedef struct {
    logic            ok;
    logic [4:0]      flags;
    logic [7:0]      ld;
    logic [CNTW-1:0] pc;
    logic [CNTW-1:0] ec;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic EN  = 1'b1;
  logic CLR = 1'b0;
  logic            PKT_DONE, PKT_OK;
  logic [CNTW-1:0] PKT_CNT, ERR_CNT;
  logic [4:0]      ERR_FLAGS;
  logic [7:0]      LAST_DATA;

  num_check_if #(.TDATAW(32), .TDESTW(4), .TIDW(2)) axis ();

  num_check #(
    .TDATAW(32), .TDESTW(4), .TIDW(2), .LFSR_DW(7), .NUM_PACKETS(NP),
    .MY_DEST(4'h1), .CHECK_SEQ(1'b1), .CNTW(CNTW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .CLR       (CLR),
    .AXIS_S    (axis),
    .PKT_DONE  (PKT_DONE),
    .PKT_OK    (PKT_OK),
    .PKT_CNT   (PKT_CNT),
    .ERR_CNT   (ERR_CNT),
    .ERR_FLAGS (ERR_FLAGS),
    .LAST_DATA (LAST_DATA)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];
  beat_t pkt[$];
  logic [CNTW-1:0] m_pc = '0, m_ec = '0;
  logic [4:0]      m_flags = '0;
  bit              cnt_pend = 0;
  logic [CNTW-1:0] pend_pc, pend_ec;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference step written as a polynomial tap mask and parity.
  function automatic logic [7:0] ref_next(input logic [7:0] d);
    logic [7:0] sh;
    sh = d << 1;
    return sh | {7'd0, ^(d & 8'hB8)};
  endfunction

  // Packet-level model: walk the beats, accumulate error causes.
  function automatic void model(output logic [4:0] fl, output logic [7:0] ld);
    int idx = 0;
    bit drain = 0;
    logic [7:0] prev = '0;
    fl = '0;
    ld = '0;
    foreach (pkt[i]) begin
      ld = pkt[i].data[7:0];
      if (!drain) begin
        if (pkt[i].data[31:8] != 0) fl[0] = 1'b1;
        if (pkt[i].dest != 4'h1)    fl[1] = 1'b1;
        if (pkt[i].tid != 0)        fl[2] = 1'b1;
        if (idx > 0 && !pkt[i].gap && !pkt[i].pause && pkt[i].data[7:0] != ref_next(prev))
          fl[3] = 1'b1;
        if (pkt[i].last && idx < NP - 1) fl[4] = 1'b1;
        if (!pkt[i].last && idx == NP - 1) begin
          fl[4] = 1'b1;
          drain = 1;
        end
        prev = pkt[i].data[7:0];
        idx++;
      end
    end
  endfunction

  function automatic void add(input logic [31:0] d, input bit last, input logic [1:0] tid,
                              input logic [3:0] dest, input bit gap, input bit pause);
    beat_t b;
    b.data = d; b.last = last; b.tid = tid; b.dest = dest; b.gap = gap; b.pause = pause;
    pkt.push_back(b);
  endfunction

  task automatic drive_beat(input beat_t b);
    int t;
    @(negedge CLK);
    if (b.gap) begin
      axis.tvalid = 1'b0;
      @(negedge CLK);
    end
    axis.tdata = b.data; axis.tlast = b.last; axis.tid = b.tid; axis.tdest = b.dest;
    axis.tvalid = 1'b1;
    if (b.pause) begin
      EN = 1'b0;
      for (int k = 0; k < 3; k++) begin
        #1 check("tready_low_when_disabled", {31'd0, axis.tready}, 32'd0);
        @(negedge CLK);
      end
      EN = 1'b1;
    end
    t = 0;
    #1;
    while (!axis.tready && t < 50) begin
      @(negedge CLK);
      #1;
      t++;
    end
    if (!axis.tready) check("tready_timeout", 32'd0, 32'd1);
    @(posedge CLK);
  endtask

  task automatic send_packet(input bit expect_done);
    logic [4:0] fl;
    logic [7:0] ld;
    exp_t e;
    model(fl, ld);
    if (expect_done) begin
      m_flags = m_flags | fl;
      if (m_pc != CMAX) m_pc = m_pc + 1'b1;
      if (fl != 0 && m_ec != CMAX) m_ec = m_ec + 1'b1;
      e.ok = (fl == 0); e.flags = m_flags; e.ld = ld; e.pc = m_pc; e.ec = m_ec;
      exp_q.push_back(e);
    end
    foreach (pkt[i]) drive_beat(pkt[i]);
    @(negedge CLK);
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    pkt.delete();
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || cnt_pend) && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (exp_q.size() != 0 || cnt_pend) check("pkt_done_timeout", 32'd0, 32'd1);
    @(negedge CLK);
  endtask

  task automatic do_clear();
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    m_pc = '0; m_ec = '0; m_flags = '0;
    check("clr_pkt_cnt", 32'(PKT_CNT), 32'd0);
    check("clr_err_cnt", 32'(ERR_CNT), 32'd0);
    check("clr_flags", 32'(ERR_FLAGS), 32'd0);
  endtask

  // Monitor: pop the scoreboard on every PKT_DONE, check counters one cycle later.
  always @(negedge CLK) begin
    exp_t e;
    if (cnt_pend) begin
      check("pkt_cnt", 32'(PKT_CNT), 32'(pend_pc));
      check("err_cnt", 32'(ERR_CNT), 32'(pend_ec));
      cnt_pend = 0;
    end
    if (PKT_DONE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pkt_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pkt_ok", {31'd0, PKT_OK}, {31'd0, e.ok});
        check("err_flags", 32'(ERR_FLAGS), 32'(e.flags));
        check("last_data", 32'(LAST_DATA), 32'(e.ld));
        pend_pc = e.pc;
        pend_ec = e.ec;
        cnt_pend = 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lf;
    int len;
    bit g, p;
    logic [31:0] d;
    logic [1:0] tid;
    logic [3:0] dest;

    axis.tvalid = 1'b0; axis.tdata = '0; axis.tlast = 1'b0; axis.tid = '0; axis.tdest = 4'h1;
    repeat (3) @(negedge CLK);
    check("rst_tready", {31'd0, axis.tready}, 32'd0);
    check("rst_pkt_done", {31'd0, PKT_DONE}, 32'd0);
    check("rst_pkt_ok", {31'd0, PKT_OK}, 32'd0);
    check("rst_pkt_cnt", 32'(PKT_CNT), 32'd0);
    check("rst_err_cnt", 32'(ERR_CNT), 32'd0);
    check("rst_flags", 32'(ERR_FLAGS), 32'd0);
    check("rst_last_data", 32'(LAST_DATA), 32'd0);
    RST = 1'b0;

    // Clean back-to-back packet
    add(32'h01, 0, 0, 1, 0, 0); add(32'h02, 0, 0, 1, 0, 0);
    add(32'h04, 0, 0, 1, 0, 0); add(32'h08, 1, 0, 1, 0, 0);
    send_packet(1); wait_idle();
    // Sequence break
    add(32'h01, 0, 0, 1, 0, 0); add(32'h02, 0, 0, 1, 0, 0);
    add(32'h05, 0, 0, 1, 0, 0); add(32'h08, 1, 0, 1, 0, 0);
    send_packet(1); wait_idle();
    check("seq_flags", 32'(ERR_FLAGS), 32'h08);
    // Gap before the last beat suppresses the seq check
    add(32'h01, 0, 0, 1, 0, 0); add(32'h02, 0, 0, 1, 0, 0);
    add(32'h04, 0, 0, 1, 0, 0); add(32'h11, 1, 0, 1, 1, 0);
    send_packet(1); wait_idle();
    // Short packet, then overlength packet drained to TLAST
    add(32'h01, 0, 0, 1, 0, 0); add(32'h02, 1, 0, 1, 0, 0);
    send_packet(1); wait_idle();
    lf = 8'h01;
    for (int i = 0; i < 6; i++) begin
      add({24'd0, lf}, i == 5, 0, 1, 0, 0);
      lf = ref_next(lf);
    end
    send_packet(1); wait_idle();
    check("len_flag", {31'd0, ERR_FLAGS[4]}, 32'd1);
    // Pad/dest/id on the first beat after a clear
    do_clear();
    add(32'h0000_0101, 0, 1, 2, 0, 0); add(32'h02, 0, 0, 1, 0, 0);
    add(32'h04, 0, 0, 1, 0, 0); add(32'h08, 1, 0, 1, 0, 0);
    send_packet(1); wait_idle();
    check("pad_dest_id_flags", 32'(ERR_FLAGS), 32'h07);
    do_clear();
    add(32'h01, 0, 0, 1, 0, 0); add(32'h02, 0, 0, 1, 0, 0);
    add(32'h04, 0, 0, 1, 0, 0); add(32'h08, 1, 0, 1, 0, 0);
    send_packet(1); wait_idle();

    // Reset mid-packet: the partial packet must never report
    add(32'h01, 0, 0, 1, 0, 0); add(32'h02, 0, 0, 1, 0, 0);
    send_packet(0);
    RST = 1'b1;
    #1 check("tready_in_reset", {31'd0, axis.tready}, 32'd0);
    @(negedge CLK);
    check("rst_mid_pkt_cnt", 32'(PKT_CNT), 32'd0);
    RST = 1'b0;
    m_pc = '0; m_ec = '0; m_flags = '0;
    add(32'h01, 0, 0, 1, 0, 0); add(32'h02, 0, 0, 1, 0, 0);
    add(32'h04, 0, 0, 1, 0, 0); add(32'h08, 1, 0, 1, 0, 0);
    send_packet(1); wait_idle();

    // EN low for three cycles with TVALID high mid-packet
    add(32'h01, 0, 0, 1, 0, 0); add(32'h02, 0, 0, 1, 0, 0);
    add(32'h04, 0, 0, 1, 0, 1); add(32'h08, 1, 0, 1, 0, 0);
    send_packet(1); wait_idle();

    // Random packets; enough of them to saturate the packet counter
    for (int n = 0; n < 40; n++) begin
      lf = 8'($urandom_range(1, 255));
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : NP;
      for (int i = 0; i < len; i++) begin
        g = ($urandom_range(0, 5) == 0);
        p = ($urandom_range(0, 19) == 0);
        d = {24'd0, lf};
        if ($urandom_range(0, 11) == 0) d[7:0] = 8'($urandom);
        if ($urandom_range(0, 19) == 0) d[31:8] = 24'($urandom_range(1, 255));
        tid  = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        dest = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(2, 15)) : 4'h1;
        add(d, i == len - 1, tid, dest, g, p);
        lf = ref_next(d[7:0]);
      end
      send_packet(1);
    end
    wait_idle();
    check("pkt_cnt_saturated", 32'(PKT_CNT), 32'(CMAX));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
